// File: rtl/systolic_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_operand_feeder_if
// Purpose  : K-slice stream (valid/ready) into the systolic operand feeder.
// Revision : 1.0
// ============================================================================
interface systolic_operand_feeder_if #(
   parameter int N = 4
);
   logic           s_valid;
   logic           s_ready;
   logic           s_last;
   logic [8*N-1:0] s_a;
   logic [8*N-1:0] s_b;

   modport master (output s_valid, s_last, s_a, s_b, input s_ready);
   modport slave  (input s_valid, s_last, s_a, s_b, output s_ready);
endinterface
`default_nettype wire

// File: rtl/systolic_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_operand_feeder
// Purpose  : Skews A/B K-slices onto the PE array edges, drives the per-PE
//            clear wavefront and flags tile completion after the zero flush.
// Revision : 1.0
// ============================================================================
module systolic_operand_feeder #(
   parameter int N    = 4,
   parameter int KMAX = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   systolic_operand_feeder_if.slave  s,
   output logic [8*N-1:0]            a_west,
   output logic [8*N-1:0]            b_north,
   output logic [N*N-1:0]            clear_pe,
   output logic                      tile_done,
   output logic [$clog2(KMAX+1)-1:0] k_count,
   output logic                      k_ovf
);
   localparam int c_kw = $clog2(KMAX+1);
   localparam int c_fw = $clog2(2*N);
   localparam int c_tw = 2*N-1;
   localparam logic [c_kw-1:0] c_kmax      = c_kw'(KMAX);
   localparam logic [c_fw-1:0] c_flush_len = c_fw'(2*N-1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [c_fw-1:0]   flush_cnt_q, flush_cnt_d;
   logic [c_kw-1:0]   k_count_q, k_count_d;
   logic              k_ovf_q, k_ovf_d;
   logic              tile_done_q, tile_done_d;
   logic [c_tw-1:0]   tok_q, tok_d;

   logic ready;
   logic accept;
   logic first_beat;

   // Held low while in reset so upstream never sees a ready from a dead block.
   assign ready      = rst_n & (state_q != ST_FLUSH);
   assign accept     = s.s_valid & ready;
   assign first_beat = accept & (state_q == ST_IDLE);
   assign s.s_ready  = ready;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      k_count_d   = k_count_q;
      k_ovf_d     = k_ovf_q;
      tile_done_d = 1'b0;
      tok_d       = {tok_q[c_tw-2:0], first_beat};

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               k_count_d = c_kw'(1);
               k_ovf_d   = 1'b0;
               if (s.s_last) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = c_flush_len;
               end else begin
                  state_d = ST_STREAM;
               end
            end
         end
         ST_STREAM: begin
            if (accept) begin
               if (k_count_q == c_kmax) begin
                  k_ovf_d = 1'b1;
               end else begin
                  k_count_d = k_count_q + c_kw'(1);
               end
               if (s.s_last) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = c_flush_len;
               end
            end
         end
         ST_FLUSH: begin
            // Last beat reaches PE(N-1,N-1) after 2N-1 cycles; done lands with IDLE.
            flush_cnt_d = flush_cnt_q - c_fw'(1);
            if (flush_cnt_q == c_fw'(1)) begin
               state_d     = ST_IDLE;
               tile_done_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
         k_count_q   <= '0;
         k_ovf_q     <= 1'b0;
         tile_done_q <= 1'b0;
         tok_q       <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         k_count_q   <= k_count_d;
         k_ovf_q     <= k_ovf_d;
         tile_done_q <= tile_done_d;
         tok_q       <= tok_d;
      end
   end

   // Lane i is a 1+i deep chain; idle cycles inject +0 at every chain head.
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [7:0] a_sr_q [i+1];
      logic [7:0] a_sr_d [i+1];
      logic [7:0] b_sr_q [i+1];
      logic [7:0] b_sr_d [i+1];

      always_comb begin
         a_sr_d[0] = accept ? s.s_a[8*i +: 8] : 8'h00;
         b_sr_d[0] = accept ? s.s_b[8*i +: 8] : 8'h00;
         for (int k = 1; k <= i; k++) begin
            a_sr_d[k] = a_sr_q[k-1];
            b_sr_d[k] = b_sr_q[k-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k <= i; k++) begin
               a_sr_q[k] <= 8'h00;
               b_sr_q[k] <= 8'h00;
            end
         end else begin
            for (int k = 0; k <= i; k++) begin
               a_sr_q[k] <= a_sr_d[k];
               b_sr_q[k] <= b_sr_d[k];
            end
         end
      end

      assign a_west[8*i +: 8]  = a_sr_q[i];
      assign b_north[8*i +: 8] = b_sr_q[i];
   end

   // The clear token sits on anti-diagonal i+j exactly when the first pair arrives there.
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         assign clear_pe[i*N+j] = tok_q[i+j];
      end
   end

   assign tile_done = tile_done_q;
   assign k_count   = k_count_q;
   assign k_ovf     = k_ovf_q;
endmodule
`default_nettype wire
